// File: rtl/output_buffer_if.sv
// Sample-stream sink and frame read port of the output buffer.
// The master side is the producer/reader; the slave side is the buffer itself.
interface output_buffer_if #(
    parameter int WIDTH  = 14,
    parameter int LENGTH = 2048
);
    localparam int AW = $clog2(LENGTH);

    logic             sink_valid;
    logic             sink_sop;
    logic             sink_eop;
    logic [WIDTH-1:0] sink_data;
    logic             sink_ready;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_release;
    logic             frame_ready;
    logic             frame_error;
    logic [15:0]      frame_count;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_data, rd_addr, rd_release,
        input  sink_ready, rd_data, frame_ready, frame_error, frame_count
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_data, rd_addr, rd_release,
        output sink_ready, rd_data, frame_ready, frame_error, frame_count
    );
endinterface

// File: rtl/output_buffer.sv
// Avalon-ST frame sink: validates sop/eop framing, stores complete frames into
// two ping-pong banks and exposes the oldest finished frame on a read port.
module output_buffer #(
    parameter int WIDTH  = 14,
    parameter int LENGTH = 2048
) (
    input  logic            clk,
    input  logic            reset_n,
    output_buffer_if.slave  bus
);
    localparam int            AW   = $clog2(LENGTH);
    localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    idx, idx_nxt;
    logic [AW-1:0]    waddr;
    logic             wr_bank, wr_bank_nxt;
    logic             rd_bank;
    logic [1:0]       full, full_rel, full_nxt;
    logic             out_of_reset;
    logic             accept, release_ok, good_eop, err_nxt, we;
    logic             frame_error_r;
    logic [15:0]      frame_count_r;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] mem [0:2*LENGTH-1];

    assign bus.sink_ready  = out_of_reset && (state != WAIT_BANK);
    assign bus.frame_ready = full[rd_bank];
    assign bus.frame_error = frame_error_r;
    assign bus.frame_count = frame_count_r;
    assign bus.rd_data     = rd_data_r;

    assign accept     = bus.sink_valid && bus.sink_ready;
    assign release_ok = bus.rd_release && full[rd_bank];

    // A release in the same cycle as a completing eop is seen first by the writer.
    always_comb begin
        full_rel = full;
        if (release_ok) full_rel[rd_bank] = 1'b0;
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        wr_bank_nxt = wr_bank;
        full_nxt    = full_rel;
        we          = 1'b0;
        waddr       = idx;
        err_nxt     = 1'b0;
        good_eop    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.sink_sop) begin
                    if (bus.sink_eop) begin
                        err_nxt = 1'b1;
                    end else begin
                        we        = 1'b1;
                        waddr     = '0;
                        idx_nxt   = AW'(1);
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (bus.sink_sop) begin
                        // Abort the partial frame; this beat restarts the bank at index 0.
                        err_nxt = 1'b1;
                        if (bus.sink_eop) begin
                            state_nxt = IDLE;
                        end else begin
                            we      = 1'b1;
                            waddr   = '0;
                            idx_nxt = AW'(1);
                        end
                    end else begin
                        we = 1'b1;
                        if (idx == LAST) begin
                            if (bus.sink_eop) begin
                                good_eop = 1'b1;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = IDLE;
                            end
                        end else if (bus.sink_eop) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt = idx + AW'(1);
                        end
                    end
                end
            end
            WAIT_BANK: begin
                if (!full_rel[~wr_bank]) begin
                    wr_bank_nxt = ~wr_bank;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (good_eop) begin
            full_nxt[wr_bank] = 1'b1;
            if (!full_rel[~wr_bank]) begin
                wr_bank_nxt = ~wr_bank;
                state_nxt   = IDLE;
            end else begin
                state_nxt = WAIT_BANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            full          <= 2'b00;
            out_of_reset  <= 1'b0;
            frame_error_r <= 1'b0;
            frame_count_r <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            wr_bank       <= wr_bank_nxt;
            full          <= full_nxt;
            out_of_reset  <= 1'b1;
            frame_error_r <= err_nxt;
            if (good_eop)   frame_count_r <= frame_count_r + 16'd1;
            if (release_ok) rd_bank       <= ~rd_bank;
        end
    end

    // Sample RAM is never reset; a dropped frame simply leaves stale data behind.
    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, waddr}] <= bus.sink_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data_r <= '0;
        else          rd_data_r <= mem[{rd_bank, bus.rd_addr}];
    end
endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: framing table, hand-written corner sequences and a
// randomized run against a queue-based frame model.
module tb_output_buffer;
    localparam int WIDTH  = 14;
    localparam int LENGTH = 64;
    localparam int AW     = $clog2(LENGTH);
    localparam int K_GOOD = 0, K_EARLY = 1, K_MIDSOP = 2, K_MISS = 3, K_SOPEOP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_pulses = 0;

    output_buffer_if #(.WIDTH(WIDTH), .LENGTH(LENGTH)) bus ();
    output_buffer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (bus.frame_error === 1'b1) err_pulses++;
    end

    typedef struct {
        int kind; int pos; int base;
        int exp_err; int exp_cnt; bit exp_fr; bit chk_rd; bit rel;
    } vec_t;

    typedef struct {
        logic sop; logic eop; logic [WIDTH-1:0] d;
    } beat_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
        bus.sink_data = '0; bus.rd_addr = '0; bus.rd_release = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic beat(input logic s, input logic e, input logic [WIDTH-1:0] d);
        int guard = 0;
        bus.sink_valid = 1'b1; bus.sink_sop = s; bus.sink_eop = e; bus.sink_data = d;
        while (!bus.sink_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: sink_ready stuck at %0b, required 1", bus.sink_ready);
        end
        @(negedge clk);
        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int pos, input int base);
        case (kind)
            K_GOOD:   for (int i = 0; i < LENGTH; i++) beat(i == 0, i == LENGTH-1, WIDTH'(base + i));
            K_EARLY:  for (int i = 0; i <= pos; i++) beat(i == 0, i == pos, WIDTH'(base + i));
            K_MIDSOP: begin
                for (int i = 0; i < pos; i++) beat(i == 0, 1'b0, WIDTH'(base + 1000 + i));
                for (int i = 0; i < LENGTH; i++) beat(i == 0, i == LENGTH-1, WIDTH'(base + i));
            end
            K_MISS: begin
                for (int i = 0; i < LENGTH; i++) beat(i == 0, 1'b0, WIDTH'(base + i));
                for (int i = 0; i < 4; i++) beat(1'b0, i == 3, WIDTH'(base + 50 + i));
            end
            default:  beat(1'b1, 1'b1, WIDTH'(base));
        endcase
    endtask

    task automatic read_check(input string nm, input int addr, input logic [WIDTH-1:0] exp);
        bus.rd_addr = AW'(addr);
        @(negedge clk);
        check(nm, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic release_frame();
        bus.rd_release = 1'b1;
        @(negedge clk);
        bus.rd_release = 1'b0;
    endtask

    // Frame-level reference model for the randomized run.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] cur_q[$];
    beat_t            pend[$];
    int               n_stored = 0;
    int               good_cnt = 0;
    bit               in_frame = 1'b0;
    bit               exp_err = 1'b0;

    task automatic push_frame();
        int k = $urandom_range(0, 9);
        int p;
        beat_t b;
        if (k <= 5) begin
            for (int i = 0; i < LENGTH; i++) begin
                b.sop = (i == 0); b.eop = (i == LENGTH-1); b.d = WIDTH'($urandom); pend.push_back(b);
            end
        end else if (k == 6) begin
            p = $urandom_range(1, LENGTH-2);
            for (int i = 0; i <= p; i++) begin
                b.sop = (i == 0); b.eop = (i == p); b.d = WIDTH'($urandom); pend.push_back(b);
            end
        end else if (k == 7) begin
            p = $urandom_range(1, LENGTH-1);
            for (int i = 0; i < p; i++) begin
                b.sop = (i == 0); b.eop = 1'b0; b.d = WIDTH'($urandom); pend.push_back(b);
            end
        end else if (k == 8) begin
            for (int i = 0; i < LENGTH + 2; i++) begin
                b.sop = (i == 0); b.eop = 1'b0; b.d = WIDTH'($urandom); pend.push_back(b);
            end
        end else begin
            b.sop = $urandom_range(0, 1); b.eop = $urandom_range(0, 1); b.d = WIDTH'($urandom);
            pend.push_back(b);
        end
    endtask

    task automatic model_beat(input beat_t b);
        if (b.sop) begin
            if (in_frame) exp_err = 1'b1;
            cur_q.delete();
            if (b.eop) begin
                exp_err = 1'b1; in_frame = 1'b0;
            end else begin
                cur_q.push_back(b.d); in_frame = 1'b1;
            end
        end else if (in_frame) begin
            cur_q.push_back(b.d);
            if (b.eop) begin
                if (cur_q.size() == LENGTH) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    n_stored++; good_cnt++;
                end else begin
                    exp_err = 1'b1;
                end
                in_frame = 1'b0;
            end else if (cur_q.size() == LENGTH) begin
                exp_err = 1'b1; in_frame = 1'b0;
            end
        end
    endtask

    vec_t tbl[7];
    int   ra[4];

    initial begin
        int   e0;
        bit   rel, ready_now, rd_pend;
        int   addr;
        logic [WIDTH-1:0] rd_exp;
        beat_t b;

        tbl[0] = '{K_GOOD,    0,    0, 0, 1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{K_EARLY,  10,  200, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{K_GOOD,    0,  300, 0, 2, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{K_MIDSOP, 30,  500, 1, 3, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{K_MISS,    0,  700, 1, 3, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{K_GOOD,    0,  900, 0, 4, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{K_SOPEOP,  0,    0, 1, 4, 1'b1, 1'b0, 1'b1};
        ra[0] = 0; ra[1] = 1; ra[2] = LENGTH/2 + 3; ra[3] = LENGTH - 1;

        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_sink_ready", 32'(bus.sink_ready), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_frame_ready", 32'(bus.frame_ready), 0);
        check("rst_frame_error", 32'(bus.frame_error), 0);
        check("rst_frame_count", 32'(bus.frame_count), 0);
        reset_n = 1'b1;
        #1 check("rst_ready_before_edge", 32'(bus.sink_ready), 0);
        @(negedge clk);
        check("rst_ready_after_edge", 32'(bus.sink_ready), 1);

        for (int r = 0; r < 7; r++) begin
            e0 = err_pulses;
            send_frame(tbl[r].kind, tbl[r].pos, tbl[r].base);
            check($sformatf("tbl%0d_frame_ready", r), 32'(bus.frame_ready), 32'(tbl[r].exp_fr));
            check($sformatf("tbl%0d_frame_count", r), 32'(bus.frame_count), 32'(tbl[r].exp_cnt));
            @(negedge clk);
            check($sformatf("tbl%0d_err_pulses", r), 32'(err_pulses - e0), 32'(tbl[r].exp_err));
            if (tbl[r].chk_rd)
                for (int i = 0; i < 4; i++)
                    read_check($sformatf("tbl%0d_rd_%0d", r, ra[i]), ra[i], WIDTH'(tbl[r].base + ra[i]));
            if (tbl[r].rel) begin
                release_frame();
                check($sformatf("tbl%0d_ready_after_release", r), 32'(bus.frame_ready), 0);
            end
        end

        // Three frames without release: the third stalls until one bank is freed.
        send_frame(K_GOOD, 0, 1100);
        send_frame(K_GOOD, 0, 1200);
        check("b2b_ready_low", 32'(bus.sink_ready), 0);
        repeat (3) @(negedge clk);
        check("b2b_ready_still_low", 32'(bus.sink_ready), 0);
        check("b2b_count2", 32'(bus.frame_count), 6);
        release_frame();
        check("b2b_ready_after_release", 32'(bus.sink_ready), 1);
        send_frame(K_GOOD, 0, 1300);
        check("b2b_count3", 32'(bus.frame_count), 7);
        check("b2b_third_waits", 32'(bus.sink_ready), 0);
        read_check("b2b_rd_frame2", 5, WIDTH'(1205));
        release_frame();
        read_check("b2b_rd_frame3", 9, WIDTH'(1309));
        release_frame();
        check("b2b_empty", 32'(bus.frame_ready), 0);

        // Release in the same cycle as the completing eop avoids WAIT_BANK.
        send_frame(K_GOOD, 0, 1400);
        for (int i = 0; i < LENGTH-1; i++) beat(i == 0, 1'b0, WIDTH'(1500 + i));
        bus.rd_release = 1'b1;
        beat(1'b0, 1'b1, WIDTH'(1500 + LENGTH - 1));
        bus.rd_release = 1'b0;
        check("same_cycle_ready", 32'(bus.sink_ready), 1);
        check("same_cycle_count", 32'(bus.frame_count), 9);
        check("same_cycle_frame_ready", 32'(bus.frame_ready), 1);
        read_check("same_cycle_rd", 17, WIDTH'(1517));
        release_frame();

        // Reset mid-frame with one bank full.
        send_frame(K_GOOD, 0, 1600);
        for (int i = 0; i < 20; i++) beat(i == 0, 1'b0, WIDTH'(1700 + i));
        reset_n = 1'b0;
        #1;
        check("mid_rst_frame_ready", 32'(bus.frame_ready), 0);
        check("mid_rst_count", 32'(bus.frame_count), 0);
        check("mid_rst_sink_ready", 32'(bus.sink_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("mid_rst_ready_before_edge", 32'(bus.sink_ready), 0);
        @(negedge clk);
        check("mid_rst_ready_after_edge", 32'(bus.sink_ready), 1);
        send_frame(K_GOOD, 0, 1800);
        check("post_rst_count", 32'(bus.frame_count), 1);
        check("post_rst_frame_ready", 32'(bus.frame_ready), 1);
        read_check("post_rst_rd", 40, WIDTH'(1840));

        // Randomized run against the frame model.
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_pend = 1'b0;
        rd_exp = '0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (rd_pend) check("rnd_rd_data", 32'(bus.rd_data), 32'(rd_exp));
            check("rnd_sink_ready", 32'(bus.sink_ready), 32'(n_stored < 2));
            check("rnd_frame_ready", 32'(bus.frame_ready), 32'(n_stored > 0));
            check("rnd_frame_count", 32'(bus.frame_count), 32'(good_cnt & 16'hFFFF));
            check("rnd_frame_error", 32'(bus.frame_error), 32'(exp_err));

            if (pend.size() == 0) push_frame();
            bus.sink_valid = ($urandom_range(0, 4) != 0);
            b = pend[0];
            bus.sink_sop = b.sop; bus.sink_eop = b.eop; bus.sink_data = b.d;
            rel = (n_stored > 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            bus.rd_release = rel;
            addr = $urandom_range(0, LENGTH-1);
            bus.rd_addr = AW'(addr);
            rd_pend = !rel && (n_stored > 0);
            if (rd_pend) rd_exp = exp_q[addr];

            ready_now = (n_stored < 2);
            exp_err = 1'b0;
            if (rel && n_stored > 0) begin
                for (int i = 0; i < LENGTH; i++) void'(exp_q.pop_front());
                n_stored--;
            end
            if (bus.sink_valid && ready_now) begin
                void'(pend.pop_front());
                model_beat(b);
            end
            @(negedge clk);
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
# output_buffer

Single-clock Avalon-ST packet sink at the consumer end of the sample stream produced by the acquisition input buffer (and the downstream processing chain). It checks sop/eop framing, stores each complete LENGTH-sample frame into one of two ping-pong RAM banks, and presents finished frames on a random-access read port. Malformed frames are dropped and flagged. Backpressure is applied only when both banks hold unread frames.

## Interface
- WIDTH, 14, sample width in bits
- LENGTH, 2048, samples per frame; power of two, at least 2; AW = $clog2(LENGTH)
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sink_valid  in  1  beat present
- sink_sop  in  1  first beat of frame
- sink_eop  in  1  last beat of frame
- sink_data  in  WIDTH  sample (two's complement, stored unmodified)
- sink_ready  out  1  beat accepted when sink_valid && sink_ready (ready latency 0)
- rd_addr  in  AW  sample index into current read bank
- rd_data  out  WIDTH  registered read data
- rd_release  in  1  pulse: reader is finished with current frame
- frame_ready  out  1  a complete frame is readable
- frame_error  out  1  one-cycle pulse per framing error
- frame_count  out  16  count of good frames, wraps at 65535 -> 0

## Operation
- Storage: 2 banks x LENGTH x WIDTH. Write bank pointer wr_bank and read bank pointer rd_bank; each bank has a full flag.
- Writer FSM states: IDLE, FILL, WAIT_BANK.
- IDLE: accepted beat without sop is ignored. Accepted sop: write sample at index 0, index <= 1, go FILL. sop together with eop is an error: frame_error, stay IDLE.
- FILL: accepted beat writes at index.
  - sop: abort current frame, frame_error, restart with this beat at index 0.
  - eop at index LENGTH-1: good frame. Set full[wr_bank], increment frame_count. If full[~wr_bank] is clear (after any same-cycle release), toggle wr_bank and go IDLE; otherwise go WAIT_BANK.
  - eop at index < LENGTH-1: frame_error, drop, go IDLE.
  - no eop at index LENGTH-1: frame_error, drop, go IDLE.
- WAIT_BANK: sink_ready low; when full[~wr_bank] clears, toggle wr_bank, go IDLE.
- Reader: frame_ready = full[rd_bank]. rd_release while frame_ready clears full[rd_bank] and toggles rd_bank. rd_release while frame_ready is low is ignored.
- Dropped frames never set full and never change frame_count; partially written bank is reused.
- sink_ready = (state != WAIT_BANK) && out_of_reset, where out_of_reset is cleared by reset and set on the first clk edge after reset_n deasserts.

## Timing
- Reset values: sink_ready 0, rd_data 0, frame_ready 0, frame_error 0, frame_count 0. State IDLE, both banks empty, both pointers 0. RAM contents are not reset.
- sink_ready rises 1 clk after reset_n deasserts.
- rd_data is valid 1 cycle after rd_addr and reads bank rd_bank as sampled with the address.
- frame_ready rises the cycle after the eop beat of a good frame.
- frame_error pulses the cycle after the offending beat.
- sink_ready drops the cycle after the completing eop when entering WAIT_BANK. It rises the cycle after the releasing rd_release.
- Same cycle: rd_release and good eop. The release applies first, so a freed other bank avoids WAIT_BANK.
- reset_n asserted mid-frame or mid-read: immediate return to reset values; partial frame discarded.

## Test plan
- Reset, then one good frame (sop on ramp 0, eop at sample LENGTH-1). Expect frame_ready=1 and frame_count=1. Read address k gives k one cycle later.
- Three back-to-back good frames with no release. Frames 1-2 fill both banks and the third waits: sink_ready=0 after frame 2's eop. One rd_release gives sink_ready=1 next cycle; frame 3 is stored and frame_count=3.
- Early eop at sample 100 -> frame_error pulse, frame_count unchanged, frame_ready stays 0. Next good frame is accepted normally.
- sop at sample 500 mid-frame -> frame_error. The new frame starts at index 0, and the completed frame reads back the new data only.
- Missing eop at sample LENGTH-1 -> frame_error, state IDLE. Non-sop beats that follow are ignored until the next sop.
- reset_n pulsed low mid-frame with one bank full -> frame_ready=0, frame_count=0, sink_ready 0 then 1. A following good frame lands in bank 0.
